// File: rtl/rv32imc_3p_rf_wb_arb.sv
// RF write-back arbiter (ALU > LSU > MDU) with a one-cycle registered write port and a pending-write scoreboard.
// Optional macro RF_WB_AGING_EN: LSU/MDU age counters promote a starved unit above the ALU.
module rv32imc_3p_rf_wb_arb #(
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [31:0]       alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [31:0]       mdu_data,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy,
    output logic              c_rf_write,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_dati
);
    localparam int NREG = 1 << ADDR_W;

    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_max_wait
        $error("MAX_WAIT must fit the 3-bit age counter");
    end

    logic              gnt_alu, gnt_lsu, gnt_mdu;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_data;
    logic [NREG-1:0]   pending, pending_nxt;

`ifdef RF_WB_AGING_EN
    localparam logic [2:0] AGE_LIM = 3'(MAX_WAIT);
    logic [2:0] lsu_age, mdu_age;
    logic       lsu_prom, mdu_prom;

    assign lsu_prom = lsu_valid && (lsu_age >= AGE_LIM);
    assign mdu_prom = mdu_valid && (mdu_age >= AGE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_age <= '0;
            mdu_age <= '0;
        end else begin
            if (!lsu_valid || gnt_lsu)  lsu_age <= '0;
            else if (lsu_age != 3'd7)   lsu_age <= lsu_age + 3'd1;
            if (!mdu_valid || gnt_mdu)  mdu_age <= '0;
            else if (mdu_age != 3'd7)   mdu_age <= mdu_age + 3'd1;
        end
    end
`endif

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        gnt_mdu = 1'b0;
`ifdef RF_WB_AGING_EN
        // A promoted unit jumps the ALU; LSU wins a tie between promoted units.
        if (lsu_prom)       gnt_lsu = 1'b1;
        else if (mdu_prom)  gnt_mdu = 1'b1;
        else
`endif
        if (alu_valid)      gnt_alu = 1'b1;
        else if (lsu_valid) gnt_lsu = 1'b1;
        else if (mdu_valid) gnt_mdu = 1'b1;
    end

    assign alu_ready = gnt_alu;
    assign lsu_ready = gnt_lsu;
    assign mdu_ready = gnt_mdu;
    assign xfer      = gnt_alu | gnt_lsu | gnt_mdu;

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (gnt_lsu) begin
            sel_addr = lsu_addr;
            sel_data = lsu_data;
        end else if (gnt_mdu) begin
            sel_addr = mdu_addr;
            sel_data = mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rf_write <= 1'b0;
            rd_addr    <= '0;
            rd_dati    <= '0;
        end else begin
            c_rf_write <= xfer && (sel_addr != '0);
            if (xfer) begin
                rd_addr <= sel_addr;
                rd_dati <= sel_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-dispatch keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (c_rf_write)                 pending_nxt[rd_addr] = 1'b0;
        if (sb_set && (sb_addr != '0))  pending_nxt[sb_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];
    assign rd_busy  = pending[sb_addr];

    sb_set_on_busy: assert property (@(posedge clk) disable iff (!rst_n) !(sb_set && rd_busy));

endmodule

// File: tb/tb_rv32imc_3p_rf_wb_arb.sv
// Bench for rv32imc_3p_rf_wb_arb: reference model pushes expected RF writes, monitor pops and compares.
module tb_rv32imc_3p_rf_wb_arb;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_valid = 0, lsu_valid = 0, mdu_valid = 0;
    logic alu_ready, lsu_ready, mdu_ready;
    logic [4:0]  alu_addr = 0, lsu_addr = 0, mdu_addr = 0;
    logic [31:0] alu_data = 0, lsu_data = 0, mdu_data = 0;
    logic sb_set = 0;
    logic [4:0] sb_addr = 0, rs1_addr = 0, rs2_addr = 0;
    logic rs1_busy, rs2_busy, rd_busy, c_rf_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_dati;

    always #5 clk = ~clk;

    rv32imc_3p_rf_wb_arb #(.ADDR_W(5), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .c_rf_write(c_rf_write), .rd_addr(rd_addr), .rd_dati(rd_dati)
    );

    typedef struct {
        int          stamp;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference state: pending registers, write currently on the port, wait lengths.
    bit       pend[32];
    bit       wr_vld = 0;
    int       wr_reg = 0;
    int       lsu_wait = 0, mdu_wait = 0;
    bit       ax, lx, mx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: who must be granted, what must be written next cycle, which registers are busy.
    always @(negedge clk) begin
        int  g;
        wr_t e;
        if (!rst_n) begin
            foreach (pend[i]) pend[i] = 1'b0;
            exp_q.delete();
            wr_vld = 0;
            lsu_wait = 0;
            mdu_wait = 0;
        end else begin
            g = 0;
`ifdef RF_WB_AGING_EN
            if (lsu_valid && lsu_wait >= MAXW)      g = 2;
            else if (mdu_valid && mdu_wait >= MAXW) g = 3;
            else
`endif
            if (alu_valid)      g = 1;
            else if (lsu_valid) g = 2;
            else if (mdu_valid) g = 3;
            chk("grant", 32'({alu_ready, lsu_ready, mdu_ready}), 32'({g == 1, g == 2, g == 3}));
            chk("rs1_busy", 32'(rs1_busy), 32'(pend[rs1_addr]));
            chk("rs2_busy", 32'(rs2_busy), 32'(pend[rs2_addr]));
            chk("rd_busy", 32'(rd_busy), 32'(pend[sb_addr]));
            if (g != 0) begin
                e.stamp = cyc;
                e.addr  = (g == 1) ? alu_addr : (g == 2) ? lsu_addr : mdu_addr;
                e.data  = (g == 1) ? alu_data : (g == 2) ? lsu_data : mdu_data;
                e.we    = (e.addr != 0);
                exp_q.push_back(e);
            end
            if (wr_vld) pend[wr_reg] = 1'b0;
            if (sb_set && sb_addr != 0) pend[sb_addr] = 1'b1;
            wr_vld   = (g != 0) && (e.addr != 0);
            wr_reg   = int'(e.addr);
            lsu_wait = (lsu_valid && g != 2) ? ((lsu_wait < 7) ? lsu_wait + 1 : 7) : 0;
            mdu_wait = (mdu_valid && g != 3) ? ((mdu_wait < 7) ? mdu_wait + 1 : 7) : 0;
        end
    end

    // Monitor: compare the RF port against the queued expectation every cycle.
    initial begin
        logic [4:0]  last_a;
        logic [31:0] last_d;
        wr_t         e;
        last_a = 0;
        last_d = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_we", 32'(c_rf_write), 0);
                chk("rst_addr", 32'(rd_addr), 0);
                chk("rst_data", rd_dati, 0);
                chk("rst_busy", 32'({rs1_busy, rs2_busy, rd_busy}), 0);
                last_a = 0;
                last_d = 0;
            end else if (exp_q.size() > 0 && exp_q[0].stamp == cyc - 1) begin
                e = exp_q.pop_front();
                chk("wr_we", 32'(c_rf_write), 32'(e.we));
                chk("wr_addr", 32'(rd_addr), 32'(e.addr));
                chk("wr_data", rd_dati, e.data);
                last_a = e.addr;
                last_d = e.data;
            end else begin
                chk("idle_we", 32'(c_rf_write), 0);
                chk("hold_addr", 32'(rd_addr), 32'(last_a));
                chk("hold_data", rd_dati, last_d);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ax = alu_valid && alu_ready;
        lx = lsu_valid && lsu_ready;
        mx = mdu_valid && mdu_ready;
        @(posedge clk);
        #1;
        if (ax) alu_valid = 0;
        if (lx) lsu_valid = 0;
        if (mx) mdu_valid = 0;
        sb_set = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_mdu;
        int a;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Single ALU write with one-cycle latency.
        alu_valid = 1; alu_addr = 5; alu_data = 32'h1234_5678;
        repeat (3) tick();

        // All three compete: ALU, LSU, MDU in order.
        alu_valid = 1; alu_addr = 3; alu_data = 32'hA0A0_0003;
        lsu_valid = 1; lsu_addr = 4; lsu_data = 32'hB0B0_0004;
        mdu_valid = 1; mdu_addr = 6; mdu_data = 32'hC0C0_0006;
        repeat (5) tick();

        // Scoreboard set, busy through the write cycle, clear after it.
        sb_set = 1; sb_addr = 7;
        tick();
        rs1_addr = 7; rs2_addr = 7;
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'hD00D_0007;
        repeat (3) tick();
        chk("pend7_cleared", 32'(rs1_busy), 0);

        // Dispatch to 9 in the cycle that writes 9: set wins.
        alu_valid = 1; alu_addr = 9; alu_data = 32'h9999_0009;
        tick();
        sb_set = 1; sb_addr = 9;
        tick();
        rs1_addr = 9;
        #1 chk("pend9_set_wins", 32'(rs1_busy), 1);
        lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h0000_0909;
        repeat (3) tick();

        // x0 write is accepted but never reaches the RF.
        lsu_valid = 1; lsu_addr = 0; lsu_data = 32'hFFFF_FFFF; rs1_addr = 0;
        repeat (3) tick();

        // Continuous ALU traffic against a waiting MDU.
        first_mdu = 0;
        mdu_valid = 1; mdu_addr = 11; mdu_data = 32'hE11E_000B;
        for (int i = 1; i <= 20; i++) begin
            if (!alu_valid) begin
                alu_valid = 1;
                alu_addr  = 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            tick();
            if (mx && first_mdu == 0) first_mdu = i;
        end
        alu_valid = 0;
`ifdef RF_WB_AGING_EN
        chk("mdu_aging_grant_cycle", 32'(first_mdu), 5);
`else
        chk("mdu_starved_20", 32'(first_mdu), 0);
`endif
        repeat (4) tick();

        // Reset while the output stage is busy and an LSU request waits.
        sb_set = 1; sb_addr = 12;
        tick();
        alu_valid = 1; alu_addr = 13; alu_data = 32'h1313_1313;
        lsu_valid = 1; lsu_addr = 14; lsu_data = 32'h1414_1414;
        rs1_addr = 12;
        tick();
        rst_n = 0;
        lsu_valid = 0;
        alu_valid = 0;
        #1;
        chk("rst_mid_we", 32'(c_rf_write), 0);
        chk("rst_mid_pend12", 32'(rs1_busy), 0);
        repeat (2) tick();
        rst_n = 1;
        repeat (2) tick();

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid && $urandom_range(0, 1) == 1) begin
                alu_valid = 1;
                alu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) == 0) begin
                lsu_valid = 1;
                lsu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lsu_data  = $urandom;
            end
            if (!mdu_valid && $urandom_range(0, 2) == 0) begin
                mdu_valid = 1;
                mdu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdu_data  = $urandom;
            end
            a = $urandom_range(0, 31);
            sb_addr = 5'(a);
            sb_set  = (!pend[a] && $urandom_range(0, 3) == 0);
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            tick();
        end

        alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32imc_3p_rf_wb_arb.md
Name: rv32imc_3p_rf_wb_arb

Overview:
Write-back arbiter and scoreboard for the RV32IMC 3-stage core register file. Three requesters share the single RF write port through a registered output stage:
- ALU (single-cycle results)
- LSU (load data)
- MDU (mul/div results)

It also tracks destination registers with outstanding multi-cycle writes and reports read/write hazards to the issue stage. It sits between the execute/LSU/MDU units and the RF write port (c_rf_write, rd_addr, rd_dati).

Parameters:
- ADDR_W, 5, RF address width (32 architectural registers).
- MAX_WAIT, 4, cycles a waiting lower-priority requester tolerates before aging promotion (only with RF_WB_AGING_EN).

Ports:
- clk  in  1  core clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  32  ALU result.
- lsu_valid / lsu_ready / lsu_addr / lsu_data  in/out/in/in  1/1/ADDR_W/32  LSU write-back handshake, same semantics as ALU.
- mdu_valid / mdu_ready / mdu_addr / mdu_data  in/out/in/in  1/1/ADDR_W/32  MDU write-back handshake, same semantics as ALU.
- sb_set  in  1  issue stage dispatches a load or MDU op.
- sb_addr  in  ADDR_W  destination of the dispatched op.
- rs1_addr  in  ADDR_W  issue-stage source 1 address.
- rs2_addr  in  ADDR_W  issue-stage source 2 address.
- rs1_busy  out  1  rs1 has an outstanding write.
- rs2_busy  out  1  rs2 has an outstanding write.
- rd_busy  out  1  sb_addr already pending (WAW); issue must stall.
- c_rf_write  out  1  registered RF write enable.
- rd_addr  out  ADDR_W  registered RF write address.
- rd_dati  out  32  registered RF write data.

Behaviour:
- Reset (async, rst_n=0):
  - c_rf_write=0, rd_addr=0, rd_dati=0.
  - All scoreboard bits cleared.
  - Age counters = 0.
  - Busy outputs therefore 0.
- Handshake:
  - x_ready is combinational and is high only for the single granted requester.
  - A transfer occurs when x_valid & x_ready.
  - Requesters hold addr/data stable while valid and not ready.
- Grant:
  - At most one grant per cycle.
  - Fixed priority ALU > LSU > MDU.
  - Nothing valid -> no grant.
- Output stage:
  - On a transfer, next posedge: c_rf_write=1 (0 if addr==0), rd_addr=addr, rd_dati=data.
  - Without a transfer, c_rf_write=0 next cycle; rd_addr/rd_dati hold.
  - Latency is one cycle from acceptance to the RF write cycle.
- x0 handling:
  - Requests with addr 0 are accepted normally.
  - They never assert c_rf_write and never touch the scoreboard.
- Scoreboard (one pending bit per register, bit 0 tied to 0):
  - sb_set & sb_addr!=0 sets pending[sb_addr] at the next posedge.
  - The bit clears at the posedge ending a cycle with c_rf_write=1 and rd_addr=that register.
  - ALU writes normally hit a clear bit, so clearing has no effect.
  - Set and clear on the same register in the same cycle: set wins (bit stays 1).
- Busy outputs (combinational):
  - rs1_busy = pending[rs1_addr]; rs2_busy = pending[rs2_addr]; rd_busy = pending[sb_addr].
  - While c_rf_write is high for a register, its pending bit is still 1, so busy stays 1 (conservative).
  - From the following cycle, the RF's last-write bypass supplies the value.
- Issue-side protocol violation: sb_set while rd_busy=1 is illegal; the assertion fires in simulation.
- Reset mid-operation: in-flight request and output stage dropped; all pending bits lost; requesters must re-handshake.

Optional Feature:
RF_WB_AGING_EN.
- Defined:
  - LSU and MDU each have a 3-bit age counter.
  - The counter increments each cycle the unit is valid and not granted (saturating).
  - It clears on that unit's grant or when the unit is not valid.
  - Age >= MAX_WAIT promotes the unit above ALU.
  - If both are promoted, LSU wins.
- Undefined: strict fixed priority and no counters; the MDU can starve under continuous ALU traffic.

Test Plan:
- Reset release, then alu_valid with addr=5, data=0x1234_5678 -> alu_ready=1 the same cycle; next cycle c_rf_write=1, rd_addr=5, rd_dati=0x12345678; the cycle after, c_rf_write=0.
- Simultaneous alu(addr 3), lsu(addr 4), mdu(addr 6) held valid -> grants in order ALU, LSU, MDU on consecutive cycles (without macro); RF writes to 3, 4, 6 one cycle later each.
- Scoreboard:
  - sb_set, sb_addr=7 -> next cycle rs1_busy=1 for rs1_addr=7 and rd_busy=1 for sb_addr=7.
  - mdu write to 7 -> busy stays 1 through the c_rf_write cycle and drops the cycle after.
- sb_set to 9 in the same cycle that c_rf_write=1, rd_addr=9 -> pending[9] remains 1.
- lsu_valid with addr=0 -> lsu_ready=1, c_rf_write stays 0, busy for rs1_addr=0 stays 0.
- With RF_WB_AGING_EN and MAX_WAIT=4: ALU valid every cycle with MDU valid -> MDU granted on its 5th waiting cycle and ALU stalled that cycle. Without the macro, MDU is never granted within 20 cycles.
- rst_n asserted while lsu_valid is pending and pending[12]=1 -> all outputs 0 immediately and pending[12] cleared.
